// File: rtl/cla_addsub_serial_pkg.sv
// Shared types and constants for the digit-serial CLA adder/subtractor.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_GROUP = 4;

  // Counter width for n slices: ceil(log2(n)), never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cla_addsub_serial_if.sv
// Operand/result handshake bundle between a requester and cla_addsub_serial.
interface cla_addsub_serial_if
  import cla_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, res, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, res, cout, ovf, zero
  );

endinterface

// File: rtl/cla_addsub_serial_group.sv
// Combinational GROUP-bit carry-lookahead slice; every carry is a flat
// sum-of-products of generate/propagate terms rather than a ripple chain.
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   carry;

  assign g        = a & b;
  assign p        = a ^ b;
  assign carry[0] = cin;

  genvar gi, gj;
  generate
    for (gi = 0; gi < GROUP; gi++) begin : g_carry
      logic [gi:0] terms;
      for (gj = 0; gj <= gi; gj++) begin : g_term
        if (gj == gi) begin : g_self
          assign terms[gj] = g[gj];
        end else begin : g_chain
          assign terms[gj] = g[gj] & (&p[gi:gj+1]);
        end
      end
      assign carry[gi+1] = (|terms) | (cin & (&p[gi:0]));
    end
  endgenerate

  assign sum      = p ^ carry[GROUP-1:0];
  assign cout     = carry[GROUP];
  assign c_msb_in = carry[GROUP-1];

endmodule

// File: rtl/cla_addsub_serial.sv
// Digit-serial adder/subtractor: one CLA slice reused NUM_GROUPS times, with
// the inter-slice carry held in a register and flags captured on the last slice.
module cla_addsub_serial
  import cla_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_addsub_serial_if.slave  bus
);

  localparam int NUM_GROUPS = (GROUP >= 1) ? (WIDTH / GROUP) : 1;
  localparam int CNT_W      = cnt_width(NUM_GROUPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_GROUPS - 1);

  generate
    if (GROUP < 1) begin : g_bad_group
      $fatal(1, "cla_addsub_serial: GROUP must be at least 1");
    end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
      $fatal(1, "cla_addsub_serial: WIDTH must be a multiple of GROUP");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             sub_reg, sub_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             zero_reg, zero_next;

  logic [GROUP-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c_msb;
  logic [WIDTH-1:0] res_shifted;

  // Operands shift right each cycle so the active slice is always the low GROUP bits.
  cla_group #(
    .GROUP (GROUP)
  ) u_group (
    .a        (a_reg[GROUP-1:0]),
    .b        (b_reg[GROUP-1:0]),
    .cin      (carry_reg),
    .sum      (slice_sum),
    .cout     (slice_cout),
    .c_msb_in (slice_c_msb)
  );

  // Results enter from the top; after NUM_GROUPS shifts slice 0 sits at bit 0.
  assign res_shifted = (res_reg >> GROUP) | (WIDTH'(slice_sum) << (WIDTH - GROUP));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sub_next   = sub_reg;
    res_next   = res_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a;
          b_next     = bus.sub ? ~bus.b : bus.b;
          sub_next   = bus.sub;
          cnt_next   = '0;
          carry_next = bus.sub;
          state_next = RUN;
        end
      end
      RUN: begin
        a_next     = a_reg >> GROUP;
        b_next     = b_reg >> GROUP;
        carry_next = slice_cout;
        res_next   = res_shifted;
        if (cnt_reg == LAST_CNT) begin
          cout_next  = slice_cout ^ sub_reg;
          ovf_next   = slice_c_msb ^ slice_cout;
          zero_next  = (res_shifted == '0);
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      res_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sub_reg   <= sub_next;
      res_reg   <= res_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      zero_reg  <= zero_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.res       = res_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_cla_addsub_serial.sv
// Directed and randomized checks of cla_addsub_serial at 16/4 and 8/8.
module tb_cla_addsub_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cla_addsub_serial_if #(.WIDTH(16)) bus16 ();
  cla_addsub_serial_if #(.WIDTH(8))  bus8 ();

  cla_addsub_serial #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  cla_addsub_serial #(.WIDTH(8), .GROUP(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                      input bit verbose,
                      output logic [15:0] r, output logic c, output logic o,
                      output logic z, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus16.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus16.a        = av;
    bus16.b        = bv;
    bus16.sub      = sv;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    bus16.a        = 16'($urandom);
    bus16.b        = 16'($urandom);
    bus16.sub      = ~sv;
    lat = 0;
    while (!bus16.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = bus16.res;
    c = bus16.cout;
    o = bus16.ovf;
    z = bus16.zero;
    if (verbose)
      $display("txn a=%h b=%h sub=%0d res=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
               av, bv, sv, r, c, o, z, lat);
    @(negedge clk);
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus16.in_ready, bus16.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_hs16: got in_ready/out_valid=%b, required 10", {bus16.in_ready, bus16.out_valid});
    end
    checks++;
    if ({bus16.res, bus16.cout, bus16.ovf, bus16.zero} !== 19'h0) begin
      failures++;
      $display("FAIL reset_res16: got res=%h flags=%b, required 0000/000", bus16.res, {bus16.cout, bus16.ovf, bus16.zero});
    end
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.res, bus8.cout, bus8.ovf, bus8.zero} !== 13'h1000) begin
      failures++;
      $display("FAIL reset_8: got rdy/vld=%b res=%h, required 10/00", {bus8.in_ready, bus8.out_valid}, bus8.res);
    end
    $display("txn reset released");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] r;
    logic c, o, z;
    int lat;
    op16(16'h1234, 16'h0FFF, 1'b0, 1'b1, r, c, o, z, lat);
    checks++;
    if ({r, c, o, z} !== {16'h2233, 3'b000}) begin
      failures++;
      $display("FAIL add_basic: got res=%h c/o/z=%b, required 2233/000", r, {c, o, z});
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL add_latency: got %0d cycles, required 4", lat);
    end
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b1, r, c, o, z, lat);
    checks++;
    if ({r, c, o, z} !== {16'h0000, 3'b101}) begin
      failures++;
      $display("FAIL add_wrap: got res=%h c/o/z=%b, required 0000/101", r, {c, o, z});
    end
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b1, r, c, o, z, lat);
    checks++;
    if ({r, c, o, z} !== {16'h8000, 3'b010}) begin
      failures++;
      $display("FAIL add_ovf: got res=%h c/o/z=%b, required 8000/010", r, {c, o, z});
    end
  endtask

  task automatic test_sub();
    logic [15:0] r;
    logic c, o, z;
    int lat;
    op16(16'h0005, 16'h0007, 1'b1, 1'b1, r, c, o, z, lat);
    checks++;
    if ({r, c, o, z} !== {16'hFFFE, 3'b100}) begin
      failures++;
      $display("FAIL sub_borrow: got res=%h c/o/z=%b, required FFFE/100", r, {c, o, z});
    end
    op16(16'h8000, 16'h0001, 1'b1, 1'b1, r, c, o, z, lat);
    checks++;
    if ({r, c, o, z} !== {16'h7FFF, 3'b010}) begin
      failures++;
      $display("FAIL sub_ovf: got res=%h c/o/z=%b, required 7FFF/010", r, {c, o, z});
    end
    op16(16'h4321, 16'h4321, 1'b1, 1'b1, r, c, o, z, lat);
    checks++;
    if ({r, c, o, z} !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL sub_equal: got res=%h c/o/z=%b, required 0000/001", r, {c, o, z});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic c, o, z;
    int lat;
    int guard;
    @(negedge clk);
    bus16.a        = 16'h1234;
    bus16.b        = 16'h0FFF;
    bus16.sub      = 1'b0;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    guard = 0;
    while (!bus16.out_valid && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (guard !== 4) begin
      failures++;
      $display("FAIL bp_latency: got %0d cycles, required 4", guard);
    end
    @(negedge clk);
    bus16.a        = 16'hAAAA;
    bus16.b        = 16'h5555;
    bus16.sub      = 1'b1;
    bus16.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus16.out_valid, bus16.in_ready, bus16.res, bus16.cout, bus16.ovf, bus16.zero} !== {2'b10, 16'h2233, 3'b000}) begin
        failures++;
        $display("FAIL bp_hold%0d: got vld/rdy=%b res=%h c/o/z=%b, required 10/2233/000",
                 i, {bus16.out_valid, bus16.in_ready}, bus16.res, {bus16.cout, bus16.ovf, bus16.zero});
      end
    end
    $display("txn held result 2233 for 5 cycles under back-pressure");
    @(negedge clk);
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
    checks++;
    if ({bus16.in_ready, bus16.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL bp_handoff: got in_ready/out_valid=%b, required 10", {bus16.in_ready, bus16.out_valid});
    end
    op16(16'h00FF, 16'hFF01, 1'b0, 1'b1, r, c, o, z, lat);
    checks++;
    if ({r, c, o, z} !== {16'h0000, 3'b101} || lat !== 4) begin
      failures++;
      $display("FAIL bp_next_op: got res=%h c/o/z=%b lat=%0d, required 0000/101 lat 4", r, {c, o, z}, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] r;
    logic c, o, z;
    int lat;
    @(negedge clk);
    bus16.a        = 16'hFFFF;
    bus16.b        = 16'hFFFF;
    bus16.sub      = 1'b0;
    bus16.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus16.out_valid, bus16.in_ready, bus16.res, bus16.cout, bus16.ovf, bus16.zero} !== {2'b01, 16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL rst_mid: got vld/rdy=%b res=%h c/o/z=%b, required 01/0000/000",
               {bus16.out_valid, bus16.in_ready}, bus16.res, {bus16.cout, bus16.ovf, bus16.zero});
    end
    $display("txn reset asserted mid-run");
    @(negedge clk);
    rst_n = 1'b1;
    op16(16'h0001, 16'h0001, 1'b0, 1'b1, r, c, o, z, lat);
    checks++;
    if ({r, c, o, z} !== {16'h0002, 3'b000} || lat !== 4) begin
      failures++;
      $display("FAIL rst_next_op: got res=%h c/o/z=%b lat=%0d, required 0002/000 lat 4", r, {c, o, z}, lat);
    end
  endtask

  task automatic test_width8();
    int lat;
    @(negedge clk);
    bus8.a        = 8'h80;
    bus8.b        = 8'h80;
    bus8.sub      = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.a        = 8'h13;
    lat = 0;
    while (!bus8.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn w8 a=80 b=80 sub=0 res=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
             bus8.res, bus8.cout, bus8.ovf, bus8.zero, lat);
    checks++;
    if ({bus8.res, bus8.cout, bus8.ovf, bus8.zero} !== {8'h00, 3'b111}) begin
      failures++;
      $display("FAIL w8_result: got res=%h c/o/z=%b, required 00/111", bus8.res, {bus8.cout, bus8.ovf, bus8.zero});
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL w8_latency: got %0d cycles, required 1", lat);
    end
    @(negedge clk);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] av, bv, er, r;
    logic        sv, ec, eo, ez, c, o, z;
    logic [16:0] full;
    int          lat;
    int          bad;
    bad = 0;
    for (int n = 0; n < 4000; n++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      sv = 1'($urandom);
      if (!sv) full = {1'b0, av} + {1'b0, bv};
      else     full = {1'b0, av} - {1'b0, bv};
      er = full[15:0];
      ec = full[16];
      if (!sv) eo = (av[15] == bv[15]) && (er[15] != av[15]);
      else     eo = (av[15] != bv[15]) && (er[15] != av[15]);
      ez = (er == 16'h0);
      op16(av, bv, sv, 1'b0, r, c, o, z, lat);
      checks++;
      if ({r, c, o, z} !== {er, ec, eo, ez} || lat !== 4) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand_op: a=%h b=%h sub=%0d got res=%h c/o/z=%b lat=%0d, required %h/%b lat 4",
                   av, bv, sv, r, {c, o, z}, lat, er, {ec, eo, ez});
      end
    end
    $display("txn random batch of 4000 ops complete");
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.sub       = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.out_ready  = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.sub        = 1'b0;

    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_op();
    test_width8();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
